// File: rtl/lsu.sv
// Load/store unit: one outstanding data-memory access, lane steering for stores, extraction for loads.
// Latency: request accepted at edge N -> bus request from N+1; ready at edge M -> writeback/done pulse in M+1.
// Backpressure: ex_ready_o is high only when idle; a stalled bus is abandoned after TIMEOUT_CYC cycles.
module lsu #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic        ex_mem_read_i,
    input  logic        ex_mem_write_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic [31:0] ex_addr_i,
    input  logic [31:0] ex_wdata_i,
    input  logic [4:0]  ex_rd_i,
    output logic        dmem_valid_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_wstrb_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_ready_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        st_done_o,
    output logic        err_o,
    output logic [1:0]  err_cause_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_MISAL   = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    state_t      state_q, state_d;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  wstrb_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [4:0]  rd_q;
    logic [7:0]  cnt_q;
    logic        err_q, err_d;
    logic [1:0]  cause_q, cause_d;

    logic        accept, rw_one, rw_none, illegal, misal, go, timeout;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_wstrb;
    logic [31:0] shifted;

    // Request classification
    always_comb begin
        accept  = ex_valid_i && (state_q == IDLE);
        rw_one  = ex_mem_read_i ^ ex_mem_write_i;
        rw_none = !ex_mem_read_i && !ex_mem_write_i;
        illegal = (ex_mem_read_i && ex_mem_write_i)
               || (ex_mem_read_i && !ex_mem_write_i &&
                   (ex_funct3_i == 3'd3 || ex_funct3_i == 3'd6 || ex_funct3_i == 3'd7))
               || (ex_mem_write_i && !ex_mem_read_i && (ex_funct3_i >= 3'd3));
        misal   = !illegal && !rw_none &&
                  (((ex_funct3_i[1:0] == 2'd1) && ex_addr_i[0]) ||
                   ((ex_funct3_i[1:0] == 2'd2) && (ex_addr_i[1:0] != 2'd0)));
        go      = accept && rw_one && !illegal && !misal;
        timeout = (state_q == WAIT) && !dmem_ready_i && (cnt_q == 8'(TIMEOUT_CYC - 1));
    end

    // Store lane replication and byte strobes; loads present no strobes
    always_comb begin
        lane_wdata = 32'd0;
        lane_wstrb = 4'd0;
        if (ex_mem_write_i) begin
            case (ex_funct3_i[1:0])
                2'd0: begin
                    lane_wdata = {4{ex_wdata_i[7:0]}};
                    lane_wstrb = 4'b0001 << ex_addr_i[1:0];
                end
                2'd1: begin
                    lane_wdata = {2{ex_wdata_i[15:0]}};
                    lane_wstrb = 4'b0011 << ex_addr_i[1:0];
                end
                default: begin
                    lane_wdata = ex_wdata_i;
                    lane_wstrb = 4'b1111;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        err_d        = 1'b0;
        cause_d      = 2'b00;
        ex_ready_o   = 1'b0;
        dmem_valid_o = 1'b0;
        wb_valid_o   = 1'b0;
        st_done_o    = 1'b0;
        case (state_q)
            IDLE: begin
                ex_ready_o = 1'b1;
                if (accept && illegal) begin
                    err_d   = 1'b1;
                    cause_d = CAUSE_ILLEGAL;
                end else if (accept && misal) begin
                    err_d   = 1'b1;
                    cause_d = CAUSE_MISAL;
                end else if (go) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                dmem_valid_o = 1'b1;
                if (dmem_ready_i) begin
                    state_d = RESP;
                end else if (timeout) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            RESP: begin
                wb_valid_o = !we_q;
                st_done_o  = we_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            wstrb_q  <= 4'd0;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            rd_q     <= 5'd0;
            cnt_q    <= 8'd0;
            rdata_q  <= 32'd0;
        end else begin
            if (go) begin
                addr_q   <= ex_addr_i;
                wdata_q  <= lane_wdata;
                wstrb_q  <= lane_wstrb;
                we_q     <= ex_mem_write_i;
                funct3_q <= ex_funct3_i;
                rd_q     <= ex_rd_i;
                cnt_q    <= 8'd0;
            end else if (state_q == WAIT && !dmem_ready_i) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (state_q == WAIT && dmem_ready_i) begin
                rdata_q <= dmem_rdata_i;
            end
        end
    end

    // Load lane extraction from the captured word
    always_comb begin
        shifted = rdata_q >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'd0:    wb_data_o = {{24{shifted[7]}}, shifted[7:0]};
            3'd1:    wb_data_o = {{16{shifted[15]}}, shifted[15:0]};
            3'd4:    wb_data_o = {24'd0, shifted[7:0]};
            3'd5:    wb_data_o = {16'd0, shifted[15:0]};
            default: wb_data_o = shifted;
        endcase
    end

    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = {addr_q[31:2], 2'b00};
    assign dmem_wdata_o = wdata_q;
    assign dmem_wstrb_o = wstrb_q;
    assign wb_rd_o      = rd_q;
    assign err_o        = err_q;
    assign err_cause_o  = cause_q;

endmodule
